// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cc_pkg
//  Description : Shared constants and types for the tail-biting rate-1/2,
//                K=7 convolutional encoder (G1=171o, G2=133o).
//                  K        - constraint length
//                  SR_W     - encoder shift-register width (K-1)
//                  G1, G2   - generator polynomials, bit K-1 taps the input
//                             bit u, bit 0 taps D6 (oldest bit)
//                  cc_state_e - block FSM states
//                  cc_sym_t   - coded symbol {X,Y}
//  Revision    : 1.0 - initial release
// ============================================================================
package cc_pkg;

    localparam int K    = 7;
    localparam int SR_W = K - 1;

    localparam logic [K-1:0] G1 = 7'o171;
    localparam logic [K-1:0] G2 = 7'o133;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_PRELOAD = 2'd1,
        ST_ENCODE  = 2'd2
    } cc_state_e;

    typedef logic [1:0] cc_sym_t;

    // Parity of the generator-selected taps of the window {u, D1..D6}.
    function automatic logic cc_tap(input logic [K-1:0] win, input logic [K-1:0] g);
        return ^(win & g);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cc_core.sv
`default_nettype none
// ============================================================================
//  Module      : cc_core
//  Description : K=7 encoder state register with parallel load and shift,
//                plus combinational X/Y generator taps.
//  Ports       : clk        - rising-edge clock
//                rst_n      - asynchronous active-low reset (state -> 0)
//                load_i     - load preload_i into D1..D6 (wins over shift)
//                preload_i  - preload value, [0]=D1 .. [5]=D6
//                shift_i    - shift u_i into D1
//                u_i        - current information bit
//                sym_o      - coded symbol, [1]=X (G1), [0]=Y (G2)
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_core
    import cc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic [SR_W-1:0] preload_i,
    input  logic            shift_i,
    input  logic            u_i,
    output cc_sym_t         sym_o
);

    // d_q[0] is D1 (most recent bit), d_q[SR_W-1] is D6 (oldest bit).
    logic [SR_W-1:0] d_q;
    logic [SR_W-1:0] d_d;
    logic [K-1:0]    win;

    // Window laid out to match the generator bit order: u at bit K-1,
    // D1 at bit K-2, ..., D6 at bit 0.
    assign win[K-1] = u_i;
    generate
        for (genvar k = 0; k < SR_W; k++) begin : g_win
            assign win[K-2-k] = d_q[k];
        end
    endgenerate

    always_comb begin
        d_d = d_q;
        if (load_i) begin
            d_d = preload_i;
        end else if (shift_i) begin
            d_d = {d_q[SR_W-2:0], u_i};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
        end else begin
            d_q <= d_d;
        end
    end

    assign sym_o = {cc_tap(win, G1), cc_tap(win, G2)};

endmodule
`default_nettype wire

// File: rtl/cc_tailbite_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : cc_tailbite_encoder
//  Description : Rate-1/2, K=7 tail-biting convolutional encoder. Buffers one
//                block of BLOCK_BITS serial bits, preloads the encoder state
//                from the block tail, then emits one {X,Y} symbol per accepted
//                output handshake.
//  Ports       : clk       - rising-edge clock
//                rst_n     - asynchronous active-low reset
//                in_valid  - in_bit is valid
//                in_bit    - randomized data bit
//                in_ready  - block accepts a bit this cycle (FILL only)
//                out_valid - out_sym is valid (ENCODE only)
//                out_sym   - coded symbol, [1]=X (G1), [0]=Y (G2)
//                out_last  - marks symbol BLOCK_BITS-1 of the block
//                out_ready - downstream accepts out_sym
//  Parameters  : BLOCK_BITS - bits per block, legal range 7..1024
//  Revision    : 1.0 - initial release
// ============================================================================
module cc_tailbite_encoder
    import cc_pkg::*;
#(
    parameter int BLOCK_BITS = 96
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       out_valid,
    output logic [1:0] out_sym,
    output logic       out_last,
    input  logic       out_ready
);

    localparam int               CNT_W    = $clog2(BLOCK_BITS);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_BITS - 1);

    cc_state_e        state_q, state_d;
    logic [CNT_W-1:0] wr_idx_q, wr_idx_d;
    logic [CNT_W-1:0] rd_idx_q, rd_idx_d;

    // Block buffer carries no reset: its contents are only ever read after a
    // complete fill, so stale data is never observed.
    logic [BLOCK_BITS-1:0] blk_q;

    logic            wr_en;
    logic            core_load;
    logic            core_shift;
    logic            u_bit;
    logic [SR_W-1:0] preload;
    cc_sym_t         core_sym;

    // Tail-biting start state: D1 = last bit of the block, D6 = sixth-to-last.
    generate
        for (genvar k = 0; k < SR_W; k++) begin : g_preload
            assign preload[k] = blk_q[BLOCK_BITS-1-k];
        end
    endgenerate

    assign u_bit = blk_q[rd_idx_q];

    cc_core u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (core_load),
        .preload_i (preload),
        .shift_i   (core_shift),
        .u_i       (u_bit),
        .sym_o     (core_sym)
    );

    always_comb begin
        state_d    = state_q;
        wr_idx_d   = wr_idx_q;
        rd_idx_d   = rd_idx_q;
        wr_en      = 1'b0;
        core_load  = 1'b0;
        core_shift = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_sym    = 2'b00;

        case (state_q)
            ST_FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d = '0;
                        state_d  = ST_PRELOAD;
                    end else begin
                        wr_idx_d = wr_idx_q + 1'b1;
                    end
                end
            end

            ST_PRELOAD: begin
                core_load = 1'b1;
                rd_idx_d  = '0;
                state_d   = ST_ENCODE;
            end

            ST_ENCODE: begin
                out_valid = 1'b1;
                out_sym   = core_sym;
                out_last  = (rd_idx_q == LAST_IDX);
                if (out_ready) begin
                    core_shift = 1'b1;
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        state_d  = ST_FILL;
                    end else begin
                        rd_idx_d = rd_idx_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FILL;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            blk_q[wr_idx_q] <= in_bit;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cc_tailbite_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cc_tailbite_encoder
//  Description : Directed self-checking bench for cc_tailbite_encoder.
//                Expected symbols come from hand tables or from a circular
//                convolution of the block with G1/G2 written directly from
//                the polynomial definition.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_tailbite_encoder;

    localparam int N = 96;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       in_valid  = 1'b0;
    logic       in_bit    = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_sym;
    logic       out_last;

    int checks   = 0;
    int failures = 0;

    logic [N-1:0] blk;
    logic [1:0]   exp_sym [N];

    cc_tailbite_encoder #(.BLOCK_BITS(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sym   (out_sym),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        failures++;
        $error("FAIL %s observed=timeout expected=completion", tag);
    endtask

    function automatic logic ub(input int j);
        return blk[((j % N) + N) % N];
    endfunction

    // Circular convolution: X = u(i)+u(i-1)+u(i-2)+u(i-3)+u(i-6),
    //                       Y = u(i)+u(i-2)+u(i-3)+u(i-5)+u(i-6), indices mod N.
    task automatic model();
        for (int i = 0; i < N; i++) begin
            exp_sym[i][1] = ub(i) ^ ub(i-1) ^ ub(i-2) ^ ub(i-3) ^ ub(i-6);
            exp_sym[i][0] = ub(i) ^ ub(i-2) ^ ub(i-3) ^ ub(i-5) ^ ub(i-6);
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < N; i++) exp_sym[i] = 2'b00;
    endtask

    task automatic rand_blk();
        for (int i = 0; i < N; i++) blk[i] = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input int nbits, input bit gaps);
        int i   = 0;
        int cyc = 0;
        while (i < nbits) begin
            @(negedge clk);
            if (cyc > 4 * N) begin
                timeout_fail("send");
                break;
            end
            cyc++;
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_bit   = blk[i];
            if (in_valid && in_ready) i++;
            @(posedge clk);
        end
        if (nbits == N) begin
            // PRELOAD cycle: junk input must be refused and dropped.
            @(negedge clk);
            in_valid = 1'b1;
            in_bit   = 1'b1;
            chk("preload_out_valid", 32'(out_valid), 32'd0);
            chk("preload_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
            in_valid = 1'b0;
            chk("first_out_valid", 32'(out_valid), 32'd1);
        end
    endtask

    task automatic recv(input int nsym, input bit stalls);
        int         j    = 0;
        int         cyc  = 0;
        bit         held = 1'b0;
        logic [1:0] prev = 2'b00;
        while (j < nsym) begin
            @(negedge clk);
            if (cyc > 8 * N) begin
                timeout_fail("recv");
                break;
            end
            cyc++;
            chk("enc_in_ready", 32'(in_ready), 32'd0);
            if (held) chk("stall_stable", 32'(out_sym), 32'(prev));
            chk("out_valid", 32'(out_valid), 32'd1);
            chk($sformatf("sym%0d", j), 32'(out_sym), 32'(exp_sym[j]));
            chk($sformatf("last%0d", j), 32'(out_last), 32'(j == N - 1));
            out_ready = stalls ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_valid  = 1'($urandom_range(0, 1));
            in_bit    = 1'($urandom_range(0, 1));
            held      = !out_ready;
            prev      = out_sym;
            if (out_ready) j++;
            @(posedge clk);
        end
    endtask

    task automatic finish_block();
        logic [5:0] tail;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_out_valid", 32'(out_valid), 32'd0);
        chk("idle_out_last", 32'(out_last), 32'd0);
        for (int k = 0; k < 6; k++) tail[k] = blk[N-1-k];
        chk("tailbite_state", 32'(dut.u_core.d_q), 32'(tail));
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_last"}, 32'(out_last), 32'd0);
        chk({tag, "_out_sym"}, 32'(out_sym), 32'd0);
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b1;
    endtask

    task automatic full_block(input bit gaps, input bit stalls);
        send(N, gaps);
        recv(N, stalls);
        finish_block();
    endtask

    initial begin
        logic [14:0] prbs;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_sym", 32'(out_sym), 32'd0);
        rst_n = 1'b1;

        // All-zero block
        blk = '0;
        clear_exp();
        full_block(1'b0, 1'b0);

        // Single 1 at bit 0
        blk    = '0;
        blk[0] = 1'b1;
        clear_exp();
        exp_sym[0] = 2'b11; exp_sym[1] = 2'b10; exp_sym[2] = 2'b11;
        exp_sym[3] = 2'b11; exp_sym[4] = 2'b00; exp_sym[5] = 2'b01;
        exp_sym[6] = 2'b11;
        full_block(1'b0, 1'b0);

        // Single 1 at bit N-1: exercises the tail-biting preload
        blk      = '0;
        blk[N-1] = 1'b1;
        clear_exp();
        exp_sym[0] = 2'b10; exp_sym[1] = 2'b11; exp_sym[2] = 2'b11;
        exp_sym[3] = 2'b00; exp_sym[4] = 2'b01; exp_sym[5] = 2'b11;
        exp_sym[N-1] = 2'b11;
        full_block(1'b0, 1'b0);
        chk("bit95_state", 32'(dut.u_core.d_q), 32'h01);

        // Random blocks with input gaps and output stalls
        for (int b = 0; b < 2; b++) begin
            rand_blk();
            model();
            full_block(1'b1, 1'b1);
        end

        // Reset mid-FILL (after 40 bits), then a clean block
        rand_blk();
        send(40, 1'b0);
        do_reset("rst_fill");
        rand_blk();
        model();
        full_block(1'b1, 1'b0);

        // Reset mid-ENCODE (after 50 symbols), then a clean block
        rand_blk();
        model();
        send(N, 1'b0);
        recv(50, 1'b1);
        do_reset("rst_enc");
        rand_blk();
        model();
        full_block(1'b0, 1'b1);

        // Block fed from a 1+X^14+X^15 randomizer sequence
        prbs = 15'b100101010000000;
        for (int i = 0; i < N; i++) begin
            blk[i] = prbs[14] ^ prbs[13];
            prbs   = {prbs[13:0], prbs[14] ^ prbs[13]};
        end
        model();
        full_block(1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
